// File: rtl/pcie_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_bridge_pkg
//  Description : Shared state encoding, error payload and command-entry
//                sizing for the host-to-PCIe memory request bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_bridge_pkg;

    // Bridge FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_RESP  = RESP
    } bridge_state_t;

    // Payload returned in place of read data when the target never answers
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // A queued command is {write flag, address, write data}
    function automatic int cmd_entry_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage : pcie_bridge_pkg
`default_nettype wire

// File: rtl/pcie_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_cmd_fifo
//  Description : Synchronous command FIFO with registered storage, extra-MSB
//                read/write pointers and a combinational view of the head.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_cmd_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // Same index with differing wrap bit means the write side has lapped the read side
    assign o_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign o_head = r_mem[r_rd_ptr[IDX_W-1:0]];

    // Pointer advance; reset flushes the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage, written at the current write index
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
        end
    end

endmodule : pcie_cmd_fifo
`default_nettype wire

// File: rtl/pcie_mem_req_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_mem_req_bridge
//  Description : Host command bridge for the GPU PCIe memory port. Queues
//                read/write commands, issues them one at a time on the
//                request/ready handshake and returns one response each,
//                with a timeout guard against an unresponsive target.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_mem_req_bridge
    import pcie_bridge_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    // host command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [MEM_DATA_WIDTH-1:0] cmd_wdata,
    // host response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic                      rsp_error,
    output logic [MEM_DATA_WIDTH-1:0] rsp_data,
    // GPU memory port
    output logic                      pcie_read_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_read_addr,
    input  logic                      pcie_read_ready,
    input  logic [MEM_DATA_WIDTH-1:0] pcie_read_data,
    output logic                      pcie_write_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] pcie_write_data,
    input  logic                      pcie_write_ready,
    // status
    output logic                      busy
);

    localparam int CMD_W = cmd_entry_width(MEM_ADDR_WIDTH, MEM_DATA_WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // FIFO interface
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic [CMD_W-1:0] w_push_data;
    logic [CMD_W-1:0] w_head;

    // FSM
    bridge_state_t r_state;
    bridge_state_t w_next_state;
    logic          w_issue_done;
    logic          w_timeout;
    logic          w_rd_req;
    logic          w_wr_req;
    logic          w_target_ready;

    // Command held for the whole issue phase
    logic                      r_cmd_write;
    logic [MEM_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [MEM_DATA_WIDTH-1:0] r_cmd_data;

    // Response payload
    logic                      r_rsp_write;
    logic                      r_rsp_error;
    logic [MEM_DATA_WIDTH-1:0] r_rsp_data;

    logic [CNT_W-1:0] r_timeout_cnt;

    // Held low while reset is asserted so no command can be accepted then
    assign cmd_ready   = !w_fifo_full && !reset;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_push_data = {cmd_write, cmd_addr, cmd_wdata};

    pcie_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, pop and request decode
    always_comb begin
        w_next_state   = r_state;
        w_pop          = 1'b0;
        w_issue_done   = 1'b0;
        w_timeout      = 1'b0;
        w_rd_req       = 1'b0;
        w_wr_req       = 1'b0;
        w_target_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_wr_req       = r_cmd_write;
                w_rd_req       = !r_cmd_write;
                // Only the ready belonging to the active request type counts
                w_target_ready = r_cmd_write ? pcie_write_ready : pcie_read_ready;
                if (w_target_ready) begin
                    // A ready in the timeout cycle still completes normally
                    w_issue_done = 1'b1;
                    w_next_state = ST_RESP;
                end else if (r_timeout_cnt == C_TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the FIFO head when a command is taken for issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
        end else if (w_pop) begin
            {r_cmd_write, r_cmd_addr, r_cmd_data} <= w_head;
        end
    end

    // Cycles spent in ISSUE, cleared once the response is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timeout_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_timeout_cnt <= '0;
        end
    end

    // Response payload captured on completion or timeout, then frozen through RESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_issue_done) begin
            r_rsp_write <= r_cmd_write;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= r_cmd_write ? '0 : pcie_read_data;
        end else if (w_timeout) begin
            r_rsp_write <= r_cmd_write;
            r_rsp_error <= 1'b1;
            r_rsp_data  <= MEM_DATA_WIDTH'(ERR_DATA);
        end
    end

    assign pcie_read_request  = w_rd_req;
    assign pcie_write_request = w_wr_req;
    assign pcie_read_addr     = r_cmd_addr;
    assign pcie_write_addr    = r_cmd_addr;
    assign pcie_write_data    = r_cmd_data;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_write = r_rsp_write;
    assign rsp_error = r_rsp_error;
    assign rsp_data  = r_rsp_data;

    assign busy = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule : pcie_mem_req_bridge
`default_nettype wire

// File: tb/tb_pcie_mem_req_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_mem_req_bridge
//  Description : Self-checking bench for pcie_mem_req_bridge. Expected
//                responses are queued as commands are pushed and compared in
//                order as the bridge hands responses back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_mem_req_bridge;

    typedef struct packed {
        logic        w;
        logic        e;
        logic [31:0] d;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic        rsp_error;
    logic [31:0] rsp_data;
    logic        pcie_read_request;
    logic [15:0] pcie_read_addr;
    logic        pcie_read_ready = 1'b0;
    logic [31:0] pcie_read_data = '0;
    logic        pcie_write_request;
    logic [15:0] pcie_write_addr;
    logic [31:0] pcie_write_data;
    logic        pcie_write_ready = 1'b0;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    int   req_cycles = 0;
    int   rsp_seen   = 0;
    exp_t sb[$];

    pcie_mem_req_bridge #(
        .MEM_DATA_WIDTH (32),
        .MEM_ADDR_WIDTH (16),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_write          (rsp_write),
        .rsp_error          (rsp_error),
        .rsp_data           (rsp_data),
        .pcie_read_request  (pcie_read_request),
        .pcie_read_addr     (pcie_read_addr),
        .pcie_read_ready    (pcie_read_ready),
        .pcie_read_data     (pcie_read_data),
        .pcie_write_request (pcie_write_request),
        .pcie_write_addr    (pcie_write_addr),
        .pcie_write_data    (pcie_write_data),
        .pcie_write_ready   (pcie_write_ready),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    // Response monitor: compares each accepted response against the queue head
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (pcie_read_request || pcie_write_request) req_cycles++;
            if (rsp_valid) rsp_seen++;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected got w=%0b e=%0b d=%h, none expected",
                             rsp_write, rsp_error, rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_write !== e.w || rsp_error !== e.e || rsp_data !== e.d) begin
                        failures++;
                        $display("FAIL rsp_payload got w=%0b e=%0b d=%h, expected w=%0b e=%0b d=%h",
                                 rsp_write, rsp_error, rsp_data, e.w, e.e, e.d);
                    end
                end
            end
        end
    end

    // Global guard so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one command and wait (bounded) until it is accepted; call at a negedge
    task automatic push_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                            input logic exp_e, input logic [31:0] exp_d);
        int n = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout cmd_ready=%0b required 1", cmd_ready);
        end else begin
            e.w = w;
            e.e = exp_e;
            e.d = exp_d;
            sb.push_back(e);
            @(negedge clock);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input logic is_wr);
        int n = 0;
        while (((is_wr ? pcie_write_request : pcie_read_request) !== 1'b1) && n < 600) begin
            @(negedge clock);
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("FAIL wait_req write=%0b request=0 required 1", is_wr);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL wait_idle busy=%0b pending=%0d required 0/0", busy, sb.size());
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_error, pcie_read_request,
             pcie_write_request, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {cmd_ready, rsp_valid, rsp_write, rsp_error, pcie_read_request,
                      pcie_write_request, busy});
        end
        checks++;
        if ({rsp_data, pcie_read_addr, pcie_write_addr, pcie_write_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got %h/%h/%h/%h required all 0",
                     rsp_data, pcie_read_addr, pcie_write_addr, pcie_write_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        end
        @(negedge clock);
    endtask

    task automatic test_write_latency();
        int hi = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0010;
        cmd_wdata = 32'h1234_5678;
        e.w = 1'b1; e.e = 1'b0; e.d = 32'h0;
        sb.push_back(e);
        @(negedge clock);
        cmd_valid = 1'b0;
        checks++;
        if (pcie_write_request !== 1'b0) begin
            failures++;
            $display("FAIL wr_early request=%0b required 0 one cycle after push", pcie_write_request);
        end
        @(negedge clock);
        checks++;
        if (pcie_write_request !== 1'b1 || pcie_write_addr !== 16'h0010 ||
            pcie_write_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL wr_issue req=%0b addr=%h data=%h required 1/0010/12345678",
                     pcie_write_request, pcie_write_addr, pcie_write_data);
        end
        for (int i = 0; i < 3; i++) begin
            if (pcie_write_request === 1'b1) hi++;
            if (i == 2) pcie_write_ready = 1'b1;
            @(negedge clock);
        end
        pcie_write_ready = 1'b0;
        checks++;
        if (hi != 3 || pcie_write_request !== 1'b0 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_handshake high_cycles=%0d req=%0b rsp_valid=%0b required 3/0/1",
                     hi, pcie_write_request, rsp_valid);
        end
        wait_idle();
    endtask

    task automatic test_read();
        push_cmd(1'b0, 16'h0010, 32'h0, 1'b0, 32'h1234_5678);
        wait_req(1'b0);
        checks++;
        if (pcie_read_addr !== 16'h0010) begin
            failures++;
            $display("FAIL rd_addr got %h required 0010", pcie_read_addr);
        end
        pcie_read_ready = 1'b1;
        pcie_read_data  = 32'h1234_5678;
        @(negedge clock);
        pcie_read_ready = 1'b0;
        pcie_read_data  = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || pcie_read_request !== 1'b0) begin
            failures++;
            $display("FAIL rd_latency rsp_valid=%0b req=%0b required 1/0", rsp_valid, pcie_read_request);
        end
        wait_idle();
    endtask

    task automatic test_timeout_fill();
        int start;
        start = req_cycles;
        push_cmd(1'b1, 16'h0100, 32'h1, 1'b1, 32'hDEAD_BEEF);
        push_cmd(1'b0, 16'h0104, 32'h0, 1'b1, 32'hDEAD_BEEF);
        push_cmd(1'b1, 16'h0108, 32'h3, 1'b1, 32'hDEAD_BEEF);
        push_cmd(1'b0, 16'h010C, 32'h0, 1'b1, 32'hDEAD_BEEF);
        push_cmd(1'b1, 16'h0110, 32'h5, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fifo_full cmd_ready=%0b busy=%0b required 0/1", cmd_ready, busy);
        end
        wait_idle();
        checks++;
        if (req_cycles - start != 5 * 255) begin
            failures++;
            $display("FAIL timeout_len request_cycles=%0d required %0d", req_cycles - start, 5 * 255);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        push_cmd(1'b1, 16'h0020, 32'hA5A5_0001, 1'b0, 32'h0);
        push_cmd(1'b0, 16'h0024, 32'h0, 1'b0, 32'hCAFE_0024);
        wait_req(1'b1);
        pcie_write_ready = 1'b1;
        @(negedge clock);
        pcie_write_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_error !== 1'b0 ||
                rsp_data !== 32'h0 || pcie_read_request !== 1'b0 || pcie_write_request !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d valid=%0b w=%0b e=%0b d=%h rreq=%0b wreq=%0b required 1/1/0/0/0/0",
                         i, rsp_valid, rsp_write, rsp_error, rsp_data, pcie_read_request, pcie_write_request);
            end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        wait_req(1'b0);
        checks++;
        if (pcie_read_addr !== 16'h0024) begin
            failures++;
            $display("FAIL bp_rd_addr got %h required 0024", pcie_read_addr);
        end
        pcie_read_ready = 1'b1;
        pcie_read_data  = 32'hCAFE_0024;
        @(negedge clock);
        pcie_read_ready = 1'b0;
        pcie_read_data  = 32'h0;
        wait_idle();
    endtask

    task automatic test_stray_and_coincident();
        int snap;
        snap = rsp_seen;
        pcie_read_ready  = 1'b1;
        pcie_write_ready = 1'b1;
        @(negedge clock);
        pcie_read_ready  = 1'b0;
        pcie_write_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_seen != snap) begin
            failures++;
            $display("FAIL idle_ready busy=%0b rsp_valid=%0b required 0/0", busy, rsp_valid);
        end
        push_cmd(1'b0, 16'h0030, 32'h0, 1'b0, 32'h5555_AAAA);
        wait_req(1'b0);
        pcie_write_ready = 1'b1;
        @(negedge clock);
        pcie_write_ready = 1'b0;
        checks++;
        if (pcie_read_request !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stray_ready req=%0b rsp_valid=%0b required 1/0", pcie_read_request, rsp_valid);
        end
        pcie_read_ready = 1'b1;
        pcie_read_data  = 32'h5555_AAAA;
        @(negedge clock);
        pcie_read_ready = 1'b0;
        pcie_read_data  = 32'h0;
        wait_idle();
        push_cmd(1'b0, 16'h0034, 32'h0, 1'b0, 32'h7777_0034);
        wait_req(1'b0);
        repeat (254) @(negedge clock);
        checks++;
        if (pcie_read_request !== 1'b1) begin
            failures++;
            $display("FAIL last_issue_cycle req=%0b required 1", pcie_read_request);
        end
        pcie_read_ready = 1'b1;
        pcie_read_data  = 32'h7777_0034;
        @(negedge clock);
        pcie_read_ready = 1'b0;
        pcie_read_data  = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL coincident_ready rsp_valid=%0b error=%0b required 1/0", rsp_valid, rsp_error);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_issue();
        int snap_rsp;
        int snap_req;
        push_cmd(1'b1, 16'h0040, 32'h4040_4040, 1'b0, 32'h0);
        push_cmd(1'b0, 16'h0044, 32'h0, 1'b0, 32'h0);
        push_cmd(1'b0, 16'h0048, 32'h0, 1'b0, 32'h0);
        wait_req(1'b1);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (pcie_write_request !== 1'b0 || pcie_read_request !== 1'b0 ||
            busy !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid wreq=%0b rreq=%0b busy=%0b cmd_ready=%0b required 0/0/0/0",
                     pcie_write_request, pcie_read_request, busy, cmd_ready);
        end
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        snap_rsp = rsp_seen;
        snap_req = req_cycles;
        repeat (20) @(negedge clock);
        checks++;
        if (rsp_seen != snap_rsp || req_cycles != snap_req || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_reset rsp_cycles=%0d req_cycles=%0d busy=%0b cmd_ready=%0b required 0/0/0/1",
                     rsp_seen - snap_rsp, req_cycles - snap_req, busy, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_timeout_fill();
        test_backpressure();
        test_stray_and_coincident();
        test_reset_mid_issue();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pcie_mem_req_bridge
`default_nettype wire
